hsimple_membank_param: RTL

HSIMPLE_MEMBANK_PARAM -- requirements
Module: hsimple_membank_param

---
 rtl/hsimple_membank_param.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/hsimple_membank_param.sv
// ---------------------------------------------------------------------------
// hsimple_membank_param
// Single-port, byte-lane-maskable memory bank with a fixed, parameterised
// access latency and a req/ack handshake.
//
// Ports
//   clk    in   1        sole clock, rising edge
//   reset  in   1        synchronous active-high reset
//   req    in   1        client request, held high until ack seen
//   rwbar  in   1        1 = read, 0 = write (sampled with req)
//   addr   in   AWIDTH   word address
//   wdata  in   DWIDTH   write data, lane i = [i*LANE_BITS +: LANE_BITS]
//   lanes  in   NLANES   write byte-lane enables
//   rdata  out  DWIDTH   registered read data, held until next read
//   ack    out  1        completion acknowledge
//   err    out  1        sticky out-of-range flag (cleared by reset only)
//   busy   out  1        high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module hsimple_membank_param #(
  parameter int unsigned DWIDTH    = 256,
  parameter int unsigned LANE_BITS = 8,
  parameter int unsigned AWIDTH    = 22,
  parameter int unsigned MEM_WORDS = 25000,
  parameter int unsigned LATENCY   = 1,
  localparam int unsigned NLANES   = DWIDTH / LANE_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rwbar,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [NLANES-1:0] lanes,
  output logic [DWIDTH-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  // LATENCY is at most 15, so a 4-bit down-counter always suffices
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [AWIDTH:0] MEM_LIMIT = (AWIDTH+1)'(MEM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [AWIDTH-1:0]   r_addr;
  logic                r_rwbar;
  logic [DWIDTH-1:0]   r_wdata;
  logic [NLANES-1:0]   r_lanes;
  logic [DWIDTH-1:0]   r_rdata;
  logic                r_ack;
  logic                r_err;
  logic                r_busy;

  // Storage is deliberately left uninitialised and untouched by reset
  logic [DWIDTH-1:0]   r_mem [MEM_WORDS];

  logic                w_access;
  logic                w_in_range;
  logic [MEM_AW-1:0]   w_mem_idx;
  logic                w_do_write;

  // Access happens on the edge that ends the last WAIT cycle
  assign w_access   = (r_state == S_WAIT) && (r_cnt == '0);
  // Compare with one extra bit so MEM_WORDS == 2**AWIDTH still works;
  // out-of-range addresses never fold onto implemented words
  assign w_in_range = ({1'b0, r_addr} < MEM_LIMIT);
  assign w_mem_idx  = MEM_AW'(r_addr);
  // Reset at the access edge abandons the pending write
  assign w_do_write = w_access && !r_rwbar && w_in_range && !reset;

  // Control FSM with registered outputs; capture edge + LATENCY = access edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rwbar <= 1'b0;
      r_wdata <= '0;
      r_lanes <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_addr  <= addr;
            r_rwbar <= rwbar;
            r_wdata <= wdata;
            r_lanes <= lanes;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            if (r_rwbar) begin
              r_rdata <= w_in_range ? r_mem[w_mem_idx] : '0;
            end
            if (!w_in_range) begin
              r_err <= 1'b1;
            end
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_ACK: begin
          // Leaving ACK requires req low, so a held req cannot be recaptured
          if (!req) begin
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Lane-masked write port
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int i = 0; i < int'(NLANES); i++) begin
        if (r_lanes[i]) begin
          r_mem[w_mem_idx][i*LANE_BITS +: LANE_BITS] <= r_wdata[i*LANE_BITS +: LANE_BITS];
        end
      end
    end
  end

  assign rdata = r_rdata;
  assign ack   = r_ack;
  assign err   = r_err;
  assign busy  = r_busy;

endmodule
